// File: rtl/ymem_pkg.sv
// Shared defaults, derived sizes and fetch FSM states for the banked Y86 memory.
package ymem_pkg;
  localparam int DEF_BANKS       = 8;
  localparam int DEF_ROWS        = 64;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_WORD_BYTES  = 8;
  localparam int DEF_FETCH_BYTES = 10;

  localparam int MEM_BYTES = DEF_BANKS * DEF_ROWS;
  localparam int OFS_W     = $clog2(DEF_BANKS);
  localparam int ROW_W     = $clog2(DEF_ROWS);

  typedef enum logic [1:0] {IDLE, BEAT1, DONE} fetch_state_e;
endpackage

// File: rtl/ymem_banked_if.sv
// Fetch (A) and data (B) port bundle; master issues requests, slave is the memory.
interface ymem_banked_if
  import ymem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_BYTES  = DEF_WORD_BYTES,
  parameter int FETCH_BYTES = DEF_FETCH_BYTES
);
  logic                     a_req;
  logic [ADDR_W-1:0]        a_addr;
  logic                     a_ready;
  logic                     a_valid;
  logic [8*FETCH_BYTES-1:0] a_data;
  logic                     a_err;

  logic                     b_req;
  logic                     b_we;
  logic [ADDR_W-1:0]        b_addr;
  logic [8*WORD_BYTES-1:0]  b_wdata;
  logic                     b_valid;
  logic [8*WORD_BYTES-1:0]  b_rdata;
  logic                     b_err;

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata,
    input  a_ready, a_valid, a_data, a_err, b_valid, b_rdata, b_err
  );

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata,
    output a_ready, a_valid, a_data, a_err, b_valid, b_rdata, b_err
  );
endinterface

// File: rtl/ymem_bank.sv
// One byte-wide bank: A read port, B read/write port, registered reads, read-before-write.
module ymem_bank #(
  parameter int ROWS  = 64,
  parameter int ROW_W = 6
) (
  input  logic             clock,
  input  logic [ROW_W-1:0] a_row_i,
  output logic [7:0]       a_rd_o,
  input  logic [ROW_W-1:0] b_row_i,
  input  logic             b_we_i,
  input  logic [7:0]       b_wd_i,
  output logic [7:0]       b_rd_o
);
  logic [7:0] mem_q [ROWS];

  always_ff @(posedge clock) begin
    a_rd_o <= mem_q[a_row_i];
    b_rd_o <= mem_q[b_row_i];
    if (b_we_i) mem_q[b_row_i] <= b_wd_i;
  end
endmodule

// File: rtl/ymem_banked.sv
// Banked byte-addressable dual-port memory: 2-beat instruction fetch on A, one-cycle quad access on B.
module ymem_banked
  import ymem_pkg::*;
#(
  parameter int BANKS       = DEF_BANKS,
  parameter int ROWS        = DEF_ROWS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_BYTES  = DEF_WORD_BYTES,
  parameter int FETCH_BYTES = DEF_FETCH_BYTES
) (
  input  logic          clock,
  input  logic          reset_n,
  ymem_banked_if.slave  bus
);
  localparam int OFS_BITS = $clog2(BANKS);
  localparam int ROW_BITS = $clog2(ROWS);
  localparam int POS_W    = OFS_BITS + ROW_BITS;
  localparam int MEM_B    = BANKS * ROWS;
  localparam int AW1      = ADDR_W + 1;
  localparam int TAIL     = FETCH_BYTES - BANKS;

  // Widened by one bit so a start address near the top of the address space cannot wrap.
  function automatic logic in_range(input logic [ADDR_W-1:0] x, input int n);
    logic [AW1-1:0] last;
    last = {1'b0, x} + AW1'(n - 1);
    return last <= AW1'(MEM_B - 1);
  endfunction

  fetch_state_e                     state_q;
  logic [POS_W-1:0]                 addr_q;
  logic                             a_inr_q;
  logic [BANKS-1:0][7:0]            beat0_q;
  logic                             a_ready_q, a_valid_q, a_err_q;
  logic [8*FETCH_BYTES-1:0]         a_data_q;
  logic                             b_valid_q, b_err_q, b_ok_q;
  logic [OFS_BITS-1:0]              b_ofs_q;

  logic [POS_W-1:0]                 a_pos;
  logic [OFS_BITS-1:0]              a_ofs, b_ofs;
  logic [ROW_BITS-1:0]              a_row, b_row;
  logic                             b_in, b_wr;
  logic [BANKS-1:0][7:0]            wpad, a_rd, b_rd, a_lane;
  logic [WORD_BYTES-1:0][7:0]       b_word;

  // Beat 0 addresses the request directly; beat 1 continues BANKS bytes further on.
  assign a_pos = (state_q == IDLE) ? bus.a_addr[POS_W-1:0] : addr_q + POS_W'(BANKS);
  assign a_ofs = a_pos[OFS_BITS-1:0];
  assign a_row = a_pos[OFS_BITS +: ROW_BITS];
  assign b_ofs = bus.b_addr[OFS_BITS-1:0];
  assign b_row = bus.b_addr[OFS_BITS +: ROW_BITS];
  assign b_in  = in_range(bus.b_addr, WORD_BYTES);
  assign b_wr  = bus.b_req && bus.b_we && b_in && reset_n;
  assign wpad  = (8*BANKS)'(bus.b_wdata);

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    logic [OFS_BITS-1:0] lane_b;
    logic [ROW_BITS-1:0] row_a, row_b;
    logic                we;

    assign lane_b = OFS_BITS'(g) - b_ofs;
    assign row_a  = (OFS_BITS'(g) >= a_ofs) ? a_row : a_row + 1'b1;
    assign row_b  = (OFS_BITS'(g) >= b_ofs) ? b_row : b_row + 1'b1;
    assign we     = b_wr && ({1'b0, lane_b} < (OFS_BITS+1)'(WORD_BYTES));

    ymem_bank #(.ROWS(ROWS), .ROW_W(ROW_BITS)) u_bank (
      .clock   (clock),
      .a_row_i (row_a),
      .a_rd_o  (a_rd[g]),
      .b_row_i (row_b),
      .b_we_i  (we),
      .b_wd_i  (wpad[lane_b]),
      .b_rd_o  (b_rd[g])
    );
  end

  // Rotate registered bank outputs back into address order.
  always_comb begin
    a_lane = '0;
    b_word = '0;
    for (int k = 0; k < BANKS; k++)      a_lane[k] = a_rd[OFS_BITS'(k) + addr_q[OFS_BITS-1:0]];
    for (int k = 0; k < WORD_BYTES; k++) b_word[k] = b_rd[OFS_BITS'(k) + b_ofs_q];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      a_inr_q   <= 1'b0;
      beat0_q   <= '0;
      a_ready_q <= 1'b1;
      a_valid_q <= 1'b0;
      a_err_q   <= 1'b0;
      a_data_q  <= '0;
    end else begin
      a_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.a_req) begin
          addr_q    <= bus.a_addr[POS_W-1:0];
          a_inr_q   <= in_range(bus.a_addr, FETCH_BYTES);
          a_ready_q <= 1'b0;
          state_q   <= BEAT1;
        end
        BEAT1: begin
          beat0_q <= a_lane;
          state_q <= DONE;
        end
        DONE: begin
          a_valid_q <= 1'b1;
          a_err_q   <= !a_inr_q;
          a_data_q  <= a_inr_q ? {a_lane[TAIL-1:0], beat0_q} : '0;
          a_ready_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      b_valid_q <= 1'b0;
      b_err_q   <= 1'b0;
      b_ok_q    <= 1'b0;
      b_ofs_q   <= '0;
    end else begin
      b_valid_q <= bus.b_req;
      b_err_q   <= bus.b_req && !b_in;
      b_ok_q    <= bus.b_req && !bus.b_we && b_in;
      b_ofs_q   <= b_ofs;
    end
  end

  assign bus.a_ready = a_ready_q;
  assign bus.a_valid = a_valid_q;
  assign bus.a_err   = a_err_q;
  assign bus.a_data  = a_data_q;
  assign bus.b_valid = b_valid_q;
  assign bus.b_err   = b_err_q;
  assign bus.b_rdata = b_ok_q ? b_word : '0;
endmodule

// File: tb/tb_ymem_banked.sv
// Scoreboard bench: drivers push expected responses, a negedge monitor pops and compares.
module tb_ymem_banked;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ymem_banked_if bus();
  ymem_banked dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  typedef struct { logic [63:0] d; logic [63:0] m; logic e; int c; } bexp_t;
  typedef struct { logic [79:0] d; logic e; int c; } aexp_t;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  bexp_t bq[$];
  aexp_t aq[$];
  bexp_t bx;
  aexp_t ax;
  int cyc = 0, checks = 0, errors = 0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (bus.b_valid) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected cyc=%0d rdata=%h err=%b", cyc, bus.b_rdata, bus.b_err);
      end else begin
        bx = bq.pop_front();
        if (((bus.b_rdata & bx.m) !== (bx.d & bx.m)) || bus.b_err !== bx.e || cyc != bx.c) begin
          errors++;
          $display("FAIL b_resp got rdata=%h err=%b cyc=%0d want rdata=%h (mask %h) err=%b cyc=%0d",
                   bus.b_rdata, bus.b_err, cyc, bx.d, bx.m, bx.e, bx.c);
        end
      end
    end
    if (bus.a_valid) begin
      checks++;
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected cyc=%0d data=%h err=%b", cyc, bus.a_data, bus.a_err);
      end else begin
        ax = aq.pop_front();
        if (bus.a_data !== ax.d || bus.a_err !== ax.e || cyc != ax.c) begin
          errors++;
          $display("FAIL a_resp got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d",
                   bus.a_data, bus.a_err, cyc, ax.d, ax.e, ax.c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    bus.b_we  = 1'b0;
  endtask

  task automatic b_issue(input logic we, input logic [15:0] addr, input logic [63:0] wd,
                         input logic [63:0] ed, input logic [63:0] em, input logic ee);
    bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    bq.push_back('{d: ed, m: em, e: ee, c: cyc + 1});
  endtask

  task automatic a_issue(input logic [15:0] addr, input logic [79:0] ed, input logic ee);
    bus.a_req = 1'b1; bus.a_addr = addr;
    aq.push_back('{d: ed, e: ee, c: cyc + 3});
  endtask

  task automatic bw(input logic [15:0] addr, input logic [63:0] wd);
    b_issue(1'b1, addr, wd, 64'h0, ONES, 1'b0);
    tick();
  endtask

  task automatic br(input logic [15:0] addr, input logic [63:0] ed, input logic ee);
    b_issue(1'b0, addr, 64'h0, ed, ONES, ee);
    tick();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.a_ready && n < 20) begin @(negedge clock); n++; end
    chk("a_ready_wait", 80'(bus.a_ready), 80'(1));
  endtask

  task automatic fetch(input logic [15:0] addr, input logic [79:0] ed, input logic ee);
    int n = 0;
    wait_ready();
    a_issue(addr, ed, ee);
    tick();
    chk("a_ready_drop", 80'(bus.a_ready), 80'(0));
    while (aq.size() != 0 && n < 20) begin @(negedge clock); n++; end
    chk("a_drain", 80'(aq.size()), 80'(0));
  endtask

  initial begin
    logic [63:0] e;
    bus.a_req = 0; bus.a_addr = 0; bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
    repeat (3) @(negedge clock);
    chk("rst_a_ready", 80'(bus.a_ready), 80'(1));
    chk("rst_a_valid", 80'(bus.a_valid), 80'(0));
    chk("rst_a_err",   80'(bus.a_err),   80'(0));
    chk("rst_a_data",  bus.a_data,       80'(0));
    chk("rst_b_valid", 80'(bus.b_valid), 80'(0));
    chk("rst_b_err",   80'(bus.b_err),   80'(0));
    chk("rst_b_rdata", 80'(bus.b_rdata), 80'(0));
    reset_n = 1'b1;
    tick();

    // unaligned write/read
    bw(16'h003, 64'h1122334455667788);
    br(16'h003, 64'h1122334455667788, 1'b0);
    b_issue(1'b0, 16'h000, 64'h0, 64'h4455667788000000, 64'hFFFFFFFFFF000000, 1'b0);
    tick();

    // fetch timing
    bw(16'h010, 64'h0706050403020100);
    bw(16'h018, 64'h0F0E0D0C0B0A0908);
    bw(16'h020, 64'h1716151413121110);
    fetch(16'h010, 80'h09080706050403020100, 1'b0);

    // back-to-back reads
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 8; j++) e[8*j +: 8] = 8'(k + j);
      b_issue(1'b0, 16'(16'h010 + k), 64'h0, e, ONES, 1'b0);
      tick();
    end

    // range boundaries
    bw(16'h1F6, 64'hA7A6A5A4A3A2A1A0);
    bw(16'h1F8, 64'hB7B6B5B4B3B2B1B0);
    fetch(16'h1F6, 80'hB7B6B5B4B3B2B1B0A1A0, 1'b0);
    fetch(16'h1F7, 80'h0, 1'b1);
    b_issue(1'b1, 16'h1F9, 64'hDEADBEEFCAFEF00D, 64'h0, ONES, 1'b1);
    tick();
    br(16'h1F8, 64'hB7B6B5B4B3B2B1B0, 1'b0);
    br(16'h1F9, 64'h0, 1'b1);
    br(16'hFFFC, 64'h0, 1'b1);

    // same-cycle collision: fetch sees old bytes
    bw(16'h040, 64'h4746454443424140);
    bw(16'h048, 64'h4F4E4D4C4B4A4948);
    wait_ready();
    b_issue(1'b1, 16'h040, ONES, 64'h0, ONES, 1'b0);
    fetch(16'h040, 80'h49484746454443424140, 1'b0);
    fetch(16'h040, 80'h4948FFFFFFFFFFFFFFFF, 1'b0);

    // reset during BEAT1 with a write in the reset cycle
    bw(16'h080, 64'h8786858483828180);
    wait_ready();
    bus.a_req = 1'b1; bus.a_addr = 16'h080;
    tick();
    reset_n = 1'b0;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h080; bus.b_wdata = 64'h5555555555555555;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_a_ready", 80'(bus.a_ready), 80'(1));
    repeat (5) tick();
    br(16'h080, 64'h8786858483828180, 1'b0);

    repeat (4) tick();
    chk("bq_drained", 80'(bq.size()), 80'(0));
    chk("aq_drained", 80'(aq.size()), 80'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ymem_banked.md
Name: ymem_banked

Overview:
- Byte-addressable, little-endian, dual-port main memory for the Y86 core.
- Successor to the single-byte dual-port RAM: storage is split into BANKS byte-wide banks, so any unaligned multi-byte access that fits in one row span completes in one array cycle.
- Port A is the read-only instruction-fetch port. It returns FETCH_BYTES bytes, 10 by default, which is a full Y86 instruction.
- Port B is the data port. It reads or writes one WORD_BYTES quad.
- Both ports use a req/valid handshake, report out-of-range addresses through an err flag, and are reset by a synchronous controller.

Parameters:
- BANKS, 8: number of byte banks and bytes per row. Must be a power of 2, and BANKS >= WORD_BYTES.
- ROWS, 64: rows per bank. MEM_BYTES = BANKS*ROWS = 512.
- ADDR_W, 16: byte-address width on both ports.
- WORD_BYTES, 8: data-port access size in bytes.
- FETCH_BYTES, 10: fetch-port access size in bytes. Must satisfy BANKS < FETCH_BYTES <= 2*BANKS.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- a_req  in  1  fetch request; sampled only when a_ready=1.
- a_addr  in  ADDR_W  fetch start byte address.
- a_ready  out  1  fetch FSM is idle.
- a_valid  out  1  one-cycle pulse; a_data and a_err are valid.
- a_data  out  8*FETCH_BYTES  fetched bytes; byte k is at a_data[8k+7:8k].
- a_err  out  1  the fetch range exceeded memory.
- b_req  in  1  data request; accepted every cycle.
- b_we  in  1  1 = write, 0 = read.
- b_addr  in  ADDR_W  data start byte address.
- b_wdata  in  8*WORD_BYTES  write data, little-endian.
- b_valid  out  1  one-cycle pulse, one cycle after b_req.
- b_rdata  out  8*WORD_BYTES  read data. Zero for writes and for errors.
- b_err  out  1  the data range exceeded memory.

Behaviour:
- Reset: applies when reset_n=0 at a rising edge.
  - Outputs after reset: a_ready=1, a_valid=0, a_err=0, a_data=0, b_valid=0, b_err=0, b_rdata=0. FSM goes to IDLE.
  - Array contents are not cleared.
  - Writes presented during a reset cycle are suppressed.
  - A fetch in progress is aborted and produces no a_valid.
- Bank mapping:
  - Byte address x lives in bank x mod BANKS, row x / BANKS.
  - For an access starting at x with offset o = x mod BANKS and row r: bank b uses row r when b >= o, and row r+1 when b < o.
  - This covers BANKS consecutive bytes in one cycle.
- Range check: the access is in range when x + n - 1 <= MEM_BYTES - 1, where n is WORD_BYTES or FETCH_BYTES. The check must be done at ADDR_W+1 bits so it cannot wrap.
  - An out-of-range access performs no write.
  - It returns err=1 and data=0, with the usual valid timing.
  - There is never wrap-around to address 0.
- Port B:
  - A request at edge N produces b_valid at edge N+1.
  - Writes commit at edge N and update only the WORD_BYTES banks in the span.
  - Back-to-back requests are allowed every cycle.
- Port A FSM: IDLE -> BEAT1 -> DONE -> IDLE.
  - IDLE: a_ready=1. When a_req=1, latch the address and range result, then read bytes 0..BANKS-1. Go to BEAT1.
  - BEAT1: read bytes BANKS..FETCH_BYTES-1 starting at address+BANKS. Go to DONE.
  - DONE: a_valid=1 for one cycle and a_data is stable. Return to IDLE, with a_ready=1 in the next cycle.
  - A fetch requested at edge N yields a_valid during the cycle after edge N+2. The minimum spacing between fetch accepts is 3 cycles.
  - a_data holds its value until the next DONE.
- Collisions (same bank and row in the same cycle): a port A read alongside a port B write returns the OLD byte (read-before-write); the write still commits.
- Port A never writes, so there are no write-write conflicts.
- Reads of never-written locations: the value is X in simulation and is don't-care.

Decomposition:
- ymem_pkg holds:
  - the defaults for BANKS, ROWS, ADDR_W, WORD_BYTES and FETCH_BYTES;
  - the derived constants MEM_BYTES, OFS_W = log2(BANKS) and ROW_W = log2(ROWS);
  - the fetch FSM state enum {IDLE, BEAT1, DONE}.
- Sub-module ymem_bank: one byte-wide ROWS-deep bank with a read port for A and a read/write port for B. It has registered read data and read-before-write semantics. Instantiate BANKS copies through a generate loop.
- Top level: row/offset decode, byte rotation (bank to lane), range check, port A FSM and beat assembly.

Test Plan:
- Unaligned write/read: B writes 0x1122334455667788 to address 0x003, then reads 0x003 → b_rdata=0x1122334455667788, b_err=0. A B read at 0x000 returns byte 3 = 0x88.
- Fetch timing: preload bytes 0x10..0x19 with values 0x00..0x09, then fetch a_req at 0x010 → a_ready drops, a_valid pulses exactly 3 edges after accept, a_data=0x09080706050403020100.
- Range boundaries:
  - Fetch at 0x1F6 → a_err=0.
  - Fetch at 0x1F7 → a_err=1, a_data=0.
  - B write at 0x1F9 → b_err=1, and a later read at 0x1F8 shows the bytes unchanged.
- Collision: in the same cycle, B writes 0xFF.. to 0x040 while A fetches 0x040 → a_data bytes 0..7 hold the old values. A second fetch returns 0xFF bytes.
- Reset mid-fetch: drive reset_n=0 in BEAT1 → no a_valid, a_ready=1 after reset. A B write issued in the reset cycle is absent on readback.
- Throughput: ten consecutive b_req reads → ten consecutive b_valid pulses, each one cycle after its request and with the correct data.
